ps2_led_ctrl: RTL and testbench
===============================

PS2_LED_CTRL -- requirements
Module: ps2_led_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 2500000, ACK wait limit in CLOCK cycles (50 ms at 50 MHz).
REQ-002 Parameter MAX_TRY, default 3, total transmit attempts allowed per LED update sequence.
REQ-003 CLOCK  input  1  single system clock; all state changes on its rising edge.
REQ-004 RST_n  input  1  asynchronous, active-low reset.
REQ-005 iRxData  input  8  byte from the PS/2 receiver; valid when iRxTrig=1.
REQ-006 iRxTrig  input  1  one-cycle pulse, one per received byte.
REQ-007 iLed  input  3  requested LED state: [2]=Caps, [1]=Num, [0]=Scroll.
REQ-008 iTxDone  input  1  one-cycle pulse from the PS/2 transmitter when a byte is finished.
REQ-009 oTxReq  output  1  one-cycle transmit request to the PS/2 transmitter.
REQ-010 oTxData  output  8  byte to transmit; stable from oTxReq until iTxDone.
REQ-011 oBusy  output  1  high in every state except IDLE.
REQ-012 oErr  output  1  sticky failure flag.
REQ-013 oLed  output  3  last LED state acknowledged by the keyboard.

Function
REQ-014 States: IDLE, SEND_CMD, WAIT_TXC, WAIT_ACK1, SEND_ARG, WAIT_TXA, WAIT_ACK2.
REQ-015 IDLE: if iLed != oLed and iLed != fail_led, latch iLed into led_q, clear try counter to 0, and go to SEND_CMD next cycle.
REQ-016 SEND_CMD: assert oTxReq for exactly one cycle with oTxData=8'hED, increment try counter, then go to WAIT_TXC.
REQ-017 WAIT_TXC: on iTxDone, clear the timer and go to WAIT_ACK1.
REQ-018 WAIT_ACK1: on iRxTrig with 8'hFA, go to SEND_ARG.
REQ-019 WAIT_ACK1: on iRxTrig with 8'hFE, or on timeout, retry via SEND_CMD.
REQ-020 SEND_ARG: assert oTxReq for one cycle with oTxData={5'b0,led_q}, increment try counter, then go to WAIT_TXA.
REQ-021 WAIT_TXA: on iTxDone, clear the timer and go to WAIT_ACK2.
REQ-022 WAIT_ACK2: on 8'hFA, load oLed<=led_q, clear oErr, clear fail_led to 3'b000-invalid (valid bit cleared), and go to IDLE.
REQ-023 WAIT_ACK2: on 8'hFE or timeout, retry via SEND_ARG.
REQ-024 Timer: 22-bit counter, counts in WAIT_TXC/WAIT_ACK1/WAIT_TXA/WAIT_ACK2; timeout when the count reaches TIMEOUT-1; cleared on every state change.
REQ-025 Retry gate: if the try counter already equals MAX_TRY when a retry is due, set oErr=1, latch fail_led<=led_q (valid bit set), and go to IDLE with oLed unchanged.
REQ-026 While the fail_led valid bit is set, IDLE starts no sequence for iLed equal to fail_led; a different iLed starts normally.
REQ-027 Bytes other than FA/FE received in WAIT_ACK states are ignored and do not reset the timer.
REQ-028 iRxTrig in WAIT_TXC/WAIT_TXA or IDLE is ignored.
REQ-029 iLed changes during a sequence are ignored; the IDLE compare after completion starts a new sequence.
REQ-030 If iRxTrig and timeout occur in the same cycle, iRxTrig takes priority.
REQ-031 oTxReq is never asserted twice without an intervening iTxDone.
REQ-032 Minimum latency: iLed change to oTxReq is 2 cycles (IDLE latch, then SEND_CMD).

Reset
REQ-033 While RST_n=0 (asynchronous): state=IDLE; oTxReq=0; oTxData=8'h00; oBusy=0; oErr=0; oLed=3'b000; led_q=0; timer=0; try counter=0; fail_led valid bit cleared.
REQ-034 Reset asserted mid-sequence aborts the sequence immediately; no oTxReq is issued until a fresh IDLE compare after reset release.

Verification
REQ-035 Reset release with iLed=3'b000 -> stays IDLE, oBusy=0, no oTxReq.
REQ-036 iLed=3'b100, transmitter/keyboard model ACKs both bytes -> oTxReq with ED, then oTxReq with 04; oLed=3'b100; oBusy falls 1 cycle after the second FA.
REQ-037 First ED answered with FE, then FA; argument answered FA -> ED sent twice, 04 once, oLed=3'b100, oErr=0.
REQ-038 No ACKs at all, TIMEOUT=100 -> exactly 3 oTxReq pulses, oErr=1, oLed unchanged, IDLE; no further requests until iLed changes.
REQ-039 iLed changed 3'b001->3'b011 while in WAIT_ACK1 -> sequence completes with argument 01, then a second sequence sends ED/03; final oLed=3'b011.
REQ-040 Byte 8'h1C arrives in WAIT_ACK2, then FA -> 1C ignored, sequence completes normally; RST_n pulsed low in WAIT_TXA -> all outputs reset within that cycle.

Source files
------------

// File: rtl/ps2_led_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : ps2_led_ctrl                                                  |
// | Description: Drives the PS/2 "set LEDs" (ED + argument) exchange with ACK  |
// |              timeout, bounded retries and a sticky error flag.             |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module ps2_led_ctrl #(
    parameter int TIMEOUT = 2500000,
    parameter int MAX_TRY = 3
) (
    input  logic       CLOCK,
    input  logic       RST_n,
    input  logic [7:0] iRxData,
    input  logic       iRxTrig,
    input  logic [2:0] iLed,
    input  logic       iTxDone,
    output logic       oTxReq,
    output logic [7:0] oTxData,
    output logic       oBusy,
    output logic       oErr,
    output logic [2:0] oLed
);

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_send_cmd  = 3'd1;
    localparam logic [2:0] c_st_wait_txc  = 3'd2;
    localparam logic [2:0] c_st_wait_ack1 = 3'd3;
    localparam logic [2:0] c_st_send_arg  = 3'd4;
    localparam logic [2:0] c_st_wait_txa  = 3'd5;
    localparam logic [2:0] c_st_wait_ack2 = 3'd6;

    localparam logic [7:0] c_cmd_set_led = 8'hED;
    localparam logic [7:0] c_kbd_ack     = 8'hFA;
    localparam logic [7:0] c_kbd_resend  = 8'hFE;

    // An FA on the last command attempt still lets the argument go out, so the
    // counter must hold MAX_TRY+1 without wrapping.
    localparam int                 c_try_w    = $clog2(MAX_TRY + 2);
    localparam logic [c_try_w-1:0] c_max_try  = c_try_w'(MAX_TRY);
    localparam logic [c_try_w-1:0] c_try_one  = c_try_w'(1);
    localparam logic [21:0]        c_tmo_last = 22'(TIMEOUT - 1);

    logic [2:0]         r_state_q,    w_state_d;
    logic [2:0]         r_led_q,      w_led_d;
    logic [c_try_w-1:0] r_try_q,      w_try_d;
    logic [21:0]        r_timer_q,    w_timer_d;
    logic               r_tx_req_q,   w_tx_req_d;
    logic [7:0]         r_tx_data_q,  w_tx_data_d;
    logic               r_err_q,      w_err_d;
    logic [2:0]         r_oled_q,     w_oled_d;
    logic [2:0]         r_fail_led_q, w_fail_led_d;
    logic               r_fail_vld_q, w_fail_vld_d;

    logic w_rx_ack;
    logic w_rx_nak;
    logic w_timeout;
    logic w_out_of_tries;
    logic w_in_wait;
    logic w_start;

    always_comb begin
        w_rx_ack       = iRxTrig && (iRxData == c_kbd_ack);
        w_rx_nak       = iRxTrig && (iRxData == c_kbd_resend);
        w_timeout      = (r_timer_q == c_tmo_last);
        w_out_of_tries = (r_try_q >= c_max_try);
        w_in_wait      = (r_state_q == c_st_wait_txc)  || (r_state_q == c_st_wait_ack1) ||
                         (r_state_q == c_st_wait_txa)  || (r_state_q == c_st_wait_ack2);
        w_start        = (iLed != r_oled_q) && !(r_fail_vld_q && (iLed == r_fail_led_q));
    end

    always_comb begin
        w_state_d    = r_state_q;
        w_led_d      = r_led_q;
        w_try_d      = r_try_q;
        w_tx_req_d   = 1'b0;
        w_tx_data_d  = r_tx_data_q;
        w_err_d      = r_err_q;
        w_oled_d     = r_oled_q;
        w_fail_led_d = r_fail_led_q;
        w_fail_vld_d = r_fail_vld_q;

        case (r_state_q)
            c_st_idle: begin
                if (w_start) begin
                    w_led_d   = iLed;
                    w_try_d   = '0;
                    w_state_d = c_st_send_cmd;
                end
            end
            c_st_send_cmd: begin
                w_tx_req_d  = 1'b1;
                w_tx_data_d = c_cmd_set_led;
                w_try_d     = r_try_q + c_try_one;
                w_state_d   = c_st_wait_txc;
            end
            c_st_wait_txc: begin
                if (iTxDone) begin
                    w_state_d = c_st_wait_ack1;
                end
            end
            c_st_wait_ack1: begin
                // A received byte wins over a coincident timeout.
                if (w_rx_ack) begin
                    w_state_d = c_st_send_arg;
                end else if (w_rx_nak || w_timeout) begin
                    if (w_out_of_tries) begin
                        w_err_d      = 1'b1;
                        w_fail_led_d = r_led_q;
                        w_fail_vld_d = 1'b1;
                        w_state_d    = c_st_idle;
                    end else begin
                        w_state_d = c_st_send_cmd;
                    end
                end
            end
            c_st_send_arg: begin
                w_tx_req_d  = 1'b1;
                w_tx_data_d = {5'b00000, r_led_q};
                w_try_d     = r_try_q + c_try_one;
                w_state_d   = c_st_wait_txa;
            end
            c_st_wait_txa: begin
                if (iTxDone) begin
                    w_state_d = c_st_wait_ack2;
                end
            end
            c_st_wait_ack2: begin
                if (w_rx_ack) begin
                    w_oled_d     = r_led_q;
                    w_err_d      = 1'b0;
                    w_fail_led_d = 3'b000;
                    w_fail_vld_d = 1'b0;
                    w_state_d    = c_st_idle;
                end else if (w_rx_nak || w_timeout) begin
                    if (w_out_of_tries) begin
                        w_err_d      = 1'b1;
                        w_fail_led_d = r_led_q;
                        w_fail_vld_d = 1'b1;
                        w_state_d    = c_st_idle;
                    end else begin
                        w_state_d = c_st_send_arg;
                    end
                end
            end
            default: begin
                w_state_d = c_st_idle;
            end
        endcase
    end

    // Timer restarts on every state change and parks at the limit otherwise.
    always_comb begin
        w_timer_d = r_timer_q;
        if (w_state_d != r_state_q) begin
            w_timer_d = '0;
        end else if (w_in_wait && !w_timeout) begin
            w_timer_d = r_timer_q + 22'd1;
        end
    end

    always_ff @(posedge CLOCK or negedge RST_n) begin
        if (!RST_n) begin
            r_state_q    <= c_st_idle;
            r_led_q      <= 3'b000;
            r_try_q      <= '0;
            r_timer_q    <= '0;
            r_tx_req_q   <= 1'b0;
            r_tx_data_q  <= 8'h00;
            r_err_q      <= 1'b0;
            r_oled_q     <= 3'b000;
            r_fail_led_q <= 3'b000;
            r_fail_vld_q <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_led_q      <= w_led_d;
            r_try_q      <= w_try_d;
            r_timer_q    <= w_timer_d;
            r_tx_req_q   <= w_tx_req_d;
            r_tx_data_q  <= w_tx_data_d;
            r_err_q      <= w_err_d;
            r_oled_q     <= w_oled_d;
            r_fail_led_q <= w_fail_led_d;
            r_fail_vld_q <= w_fail_vld_d;
        end
    end

    assign oTxReq  = r_tx_req_q;
    assign oTxData = r_tx_data_q;
    assign oBusy   = (r_state_q != c_st_idle);
    assign oErr    = r_err_q;
    assign oLed    = r_oled_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_led_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_ps2_led_ctrl                                               |
// | Description: Scoreboard bench for ps2_led_ctrl with a keyboard/transmitter |
// |              responder and an attempt-level reference model.              |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_ps2_led_ctrl;

    localparam int TIMEOUT = 100;
    localparam int MAX_TRY = 3;

    localparam int c_r_ack  = 0;
    localparam int c_r_nak  = 1;
    localparam int c_r_sil  = 2;
    localparam int c_r_junk = 3;

    typedef struct {
        int code;
        bit last;
    } reply_t;

    logic       CLOCK = 1'b0;
    logic       RST_n;
    logic [7:0] iRxData;
    logic       iRxTrig;
    logic [2:0] iLed;
    logic       iTxDone;
    logic       oTxReq;
    logic [7:0] oTxData;
    logic       oBusy;
    logic       oErr;
    logic [2:0] oLed;

    ps2_led_ctrl #(
        .TIMEOUT (TIMEOUT),
        .MAX_TRY (MAX_TRY)
    ) u_dut (
        .CLOCK   (CLOCK),
        .RST_n   (RST_n),
        .iRxData (iRxData),
        .iRxTrig (iRxTrig),
        .iLed    (iLed),
        .iTxDone (iTxDone),
        .oTxReq  (oTxReq),
        .oTxData (oTxData),
        .oBusy   (oBusy),
        .oErr    (oErr),
        .oLed    (oLed)
    );

    always #5 CLOCK = ~CLOCK;

    int cyc = 0;
    always @(posedge CLOCK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    int epoch    = 0;
    int set_cyc  = 0;
    bit resp_busy   = 1'b0;
    bit outstanding = 1'b0;

    logic [7:0] exp_q[$];
    logic [7:0] txq[$];
    reply_t     reply_q[$];
    int         force_q[$];
    int         req_cyc_q[$];

    logic [2:0] m_oled = 3'b000;
    logic [2:0] m_fled = 3'b000;
    bit         m_err  = 1'b0;
    bit         m_fvld = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit m_starts(input logic [2:0] led);
        return (led != m_oled) && !(m_fvld && (led == m_fled));
    endfunction

    function automatic int next_code();
        int r;
        if (force_q.size() > 0) return force_q.pop_front();
        r = int'($urandom_range(0, 9));
        if (r < 5) return c_r_ack;
        if (r < 7) return c_r_nak;
        if (r < 8) return c_r_sil;
        return c_r_junk;
    endfunction

    // One LED update as a list of attempts: every attempt is one byte plus one
    // keyboard reaction; the sequence ends on the argument ACK or when a retry
    // is needed with the attempt budget spent.
    function automatic void model_seq(input logic [2:0] led);
        int     tries;
        bit     arg_phase;
        bit     acked;
        reply_t r;
        tries     = 0;
        arg_phase = 1'b0;
        forever begin
            exp_q.push_back(arg_phase ? {5'b00000, led} : 8'hED);
            tries++;
            r.code = next_code();
            r.last = 1'b0;
            acked  = (r.code == c_r_ack) || (r.code == c_r_junk);
            if (acked && arg_phase) begin
                m_oled = led; m_err = 1'b0; m_fvld = 1'b0; r.last = 1'b1;
            end else if (!acked && tries >= MAX_TRY) begin
                m_err = 1'b1; m_fled = led; m_fvld = 1'b1; r.last = 1'b1;
            end
            reply_q.push_back(r);
            if (r.last) return;
            if (acked) arg_phase = 1'b1;
        end
    endfunction

    // Monitor: every request is matched against the next expected byte.
    always @(negedge CLOCK) begin
        if (!RST_n) begin
            outstanding = 1'b0;
        end else begin
            if (oTxReq) begin
                check("single_outstanding_req", 32'(outstanding), 32'd0);
                outstanding = 1'b1;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_req: got oTxData=%02h, required no request (cycle %0d)", oTxData, cyc);
                end else begin
                    check("tx_byte", 32'(oTxData), 32'(exp_q.pop_front()));
                    txq.push_back(oTxData);
                    req_cyc_q.push_back(cyc);
                end
            end
            if (iTxDone) outstanding = 1'b0;
        end
    end

    // Transmitter + keyboard responder.
    initial begin
        logic [7:0] b;
        reply_t     r;
        int         e;
        int         done_c;
        iTxDone = 1'b0;
        iRxTrig = 1'b0;
        iRxData = 8'h00;
        forever begin
            while (txq.size() == 0) @(negedge CLOCK);
            b = txq.pop_front();
            e = epoch;
            resp_busy = 1'b1;
            if (reply_q.size() > 0) r = reply_q.pop_front();
            else begin r.code = c_r_sil; r.last = 1'b1; end
            @(posedge CLOCK); #1;
            if ($urandom_range(0, 1) == 1) begin
                iRxData = 8'hFA; iRxTrig = 1'b1;
                @(posedge CLOCK); #1;
                iRxTrig = 1'b0;
            end
            repeat ($urandom_range(0, 3)) @(posedge CLOCK);
            #1;
            if (epoch == e) begin
                check("tx_data_stable", 32'(oTxData), 32'(b));
                iTxDone = 1'b1;
                done_c  = cyc + 1;
                @(posedge CLOCK); #1;
                iTxDone = 1'b0;
                if (r.code == c_r_sil) begin
                    while (epoch == e && cyc < done_c + TIMEOUT - 1) @(negedge CLOCK);
                    if (epoch == e) check("busy_before_timeout", 32'(oBusy), 32'd1);
                    @(negedge CLOCK);
                    if (epoch == e) check("busy_at_timeout", 32'(oBusy), 32'(!r.last));
                    if (!r.last) begin
                        @(negedge CLOCK);
                        if (epoch == e) check("retry_req_after_timeout", 32'(oTxReq), 32'd1);
                    end
                end else begin
                    repeat ($urandom_range(1, 4)) @(posedge CLOCK);
                    #1;
                    if (r.code == c_r_junk) begin
                        iRxData = 8'h1C; iRxTrig = 1'b1;
                        @(posedge CLOCK); #1;
                        iRxTrig = 1'b0;
                        repeat ($urandom_range(1, 3)) @(posedge CLOCK);
                        #1;
                    end
                    iRxData = (r.code == c_r_nak) ? 8'hFE : 8'hFA;
                    iRxTrig = 1'b1;
                    @(posedge CLOCK); #1;
                    iRxTrig = 1'b0;
                    if (r.last && epoch == e) begin
                        @(negedge CLOCK);
                        check("busy_drop_after_final_reply", 32'(oBusy), 32'd0);
                    end
                end
            end
            resp_busy = 1'b0;
        end
    end

    task automatic wait_done(input string name);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 3000) begin
            @(negedge CLOCK);
            n++;
            ok = (exp_q.size() == 0) && (txq.size() == 0) && !resp_busy && !oBusy;
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_done: got %0d bytes still pending, required 0 within 3000 cycles", name, exp_q.size());
            exp_q.delete();
            reply_q.delete();
        end
        repeat (2) @(negedge CLOCK);
    endtask

    task automatic do_seq(input logic [2:0] led, input bit mid, input logic [2:0] led2);
        bit sa;
        sa = m_starts(led);
        if (sa) model_seq(led);
        if (sa && mid && m_starts(led2)) model_seq(led2);
        @(negedge CLOCK);
        iLed    = led;
        set_cyc = cyc;
        if (sa && mid) begin
            @(negedge CLOCK);
            check("busy_after_start", 32'(oBusy), 32'd1);
            iLed = led2;
        end
        if (sa) wait_done("seq");
        else repeat (10) @(negedge CLOCK);
        check("idle_after_seq", 32'(oBusy), 32'd0);
        check("oled_after_seq", 32'(oLed), 32'(m_oled));
        check("oerr_after_seq", 32'(oErr), 32'(m_err));
    endtask

    initial begin
        logic [2:0] led;
        int         n;
        RST_n = 1'b0;
        iLed  = 3'b000;
        repeat (3) @(posedge CLOCK);
        #1;
        check("rst_otxreq",  32'(oTxReq),  32'd0);
        check("rst_otxdata", 32'(oTxData), 32'h00);
        check("rst_obusy",   32'(oBusy),   32'd0);
        check("rst_oerr",    32'(oErr),    32'd0);
        check("rst_oled",    32'(oLed),    32'd0);
        @(negedge CLOCK);
        RST_n = 1'b1;
        repeat (10) @(negedge CLOCK);
        check("idle_after_release_busy", 32'(oBusy), 32'd0);
        check("idle_after_release_oled", 32'(oLed),  32'd0);

        // Clean exchange, plus the two-cycle request latency.
        force_q = '{c_r_ack, c_r_ack};
        req_cyc_q.delete();
        do_seq(3'b100, 1'b0, 3'b000);
        check("req_latency", (req_cyc_q.size() > 0) ? 32'(req_cyc_q[0] - set_cyc) : 32'hFFFF_FFFF, 32'd2);

        // Command refused once, then accepted.
        force_q = '{c_r_nak, c_r_ack, c_r_ack};
        do_seq(3'b101, 1'b0, 3'b000);

        // Silent keyboard: three attempts, then the failure is sticky for this value.
        force_q = '{c_r_sil, c_r_sil, c_r_sil};
        do_seq(3'b110, 1'b0, 3'b000);
        repeat (40) @(negedge CLOCK);
        do_seq(3'b110, 1'b0, 3'b000);

        // LED request changed mid-sequence: first completes, second follows.
        force_q = '{c_r_ack, c_r_ack, c_r_ack, c_r_ack};
        do_seq(3'b001, 1'b1, 3'b011);

        // Foreign byte before the argument ACK.
        force_q = '{c_r_ack, c_r_junk};
        do_seq(3'b111, 1'b0, 3'b000);

        for (int i = 0; i < 30; i++) begin
            do_seq(3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)));
        end

        // Reset while the argument byte is in flight.
        do led = 3'($urandom_range(0, 7)); while (!m_starts(led));
        exp_q.push_back(8'hED);
        exp_q.push_back({5'b00000, led});
        reply_q.push_back('{c_r_ack, 1'b0});
        reply_q.push_back('{c_r_sil, 1'b0});
        @(negedge CLOCK);
        iLed = led;
        n = 0;
        while (exp_q.size() > 0 && n < 500) begin
            @(negedge CLOCK);
            n++;
        end
        check("reached_arg_request", 32'(exp_q.size()), 32'd0);
        #1;
        RST_n = 1'b0;
        epoch++;
        #1;
        check("midrst_otxreq",  32'(oTxReq),  32'd0);
        check("midrst_otxdata", 32'(oTxData), 32'h00);
        check("midrst_obusy",   32'(oBusy),   32'd0);
        check("midrst_oerr",    32'(oErr),    32'd0);
        check("midrst_oled",    32'(oLed),    32'd0);
        exp_q.delete();
        reply_q.delete();
        iLed   = 3'b000;
        m_oled = 3'b000;
        m_err  = 1'b0;
        m_fvld = 1'b0;
        repeat (3) @(negedge CLOCK);
        RST_n = 1'b1;
        repeat (20) @(negedge CLOCK);
        check("post_reset_idle", 32'(oBusy), 32'd0);
        check("post_reset_oled", 32'(oLed),  32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #900000;
        n_errors++;
        $display("FAIL watchdog: got simulation still running, required completion before 90000 cycles");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
